pciecfg_exec: RTL
=================

Name: pciecfg_exec

Overview:
- Consumer stage behind the NetTLP PCIe configuration FIFO.
- Pops one queued configuration request per transaction: 65-bit entry = data_valid + {udp_check, opcode, byte_mask, dwaddr, data}.
- Executes the request on the PCIe hard core's cfg_mgmt port.
- Returns a 64-bit response word to the UDP TX path over a valid/ready handshake.

Parameters:
TIMEOUT, 255, cycles cfg_mgmt enable may stay high without rd_wr_done before abort (1..65535)
WR_READONLY, 1'b0, value driven on cfg_mgmt_wr_readonly during writes

Ports:
clk  in  1  single clock (PCIe user clock domain); all logic on rising edge
rst  in  1  reset, asynchronous, active-high
fifo_empty  in  1  request FIFO empty, first-word-fall-through
fifo_dout  in  65  head entry: [64]=data_valid, [63:48]=udp_check, [47:46]=opcode, [45:42]=byte_mask, [41:32]=dwaddr, [31:0]=data
fifo_rd_en  out  1  pop head entry
cfg_mgmt_dwaddr  out  10  config DW address
cfg_mgmt_byte_en  out  4  byte enables
cfg_mgmt_di  out  32  write data
cfg_mgmt_rd_en  out  1  read strobe, held until done/timeout
cfg_mgmt_wr_en  out  1  write strobe, held until done/timeout
cfg_mgmt_wr_readonly  out  1  = WR_READONLY while wr_en, else 0
cfg_mgmt_do  in  32  read data, valid with rd_wr_done
cfg_mgmt_rd_wr_done  in  1  access complete, 1-cycle pulse
rsp_valid  out  1  response available
rsp_ready  in  1  TX path accepts response
rsp_pkt  out  64  {udp_check, opcode, byte_mask, dwaddr, data}
rsp_timeout  out  1  response caused by timeout, qualified by rsp_valid
drop_cnt  out  16  discarded entries, wraps at 16'hFFFF->0

Behaviour:
- Reset (async, while rst=1): state=IDLE; all outputs 0; rsp_pkt=0; drop_cnt=0; timeout counter=0. An in-flight access is abandoned, enables drop immediately, no response emitted.
- fifo_rd_en is combinational: state==IDLE && !fifo_empty. Entry latched at the same edge.
- States:
  - IDLE: on pop, classify the latched entry:
    - data_valid=0, or opcode 2'b10/2'b11 -> drop_cnt+1, stay IDLE, no response.
    - opcode WR with byte_mask=0 -> RESP directly; data echoes request, no cfg access.
    - Otherwise -> CFG.
  - CFG:
    - Registered outputs: dwaddr, byte_en, di (=req data) stable for the whole state. rd_en=1 for opcode RD; wr_en=1 for opcode WR.
    - Timeout counter increments each cycle.
    - On rd_wr_done=1 at an edge: enables low next cycle; response data = cfg_mgmt_do (read) or request data (write); rsp_timeout=0; -> RESP.
    - If counter reaches TIMEOUT without done: enables low; data=32'hFFFF_FFFF for read, request data for write; rsp_timeout=1; -> RESP.
    - done and timeout on the same edge: done wins.
    - Counter clears on leaving CFG.
  - RESP: rsp_valid=1; rsp_pkt/rsp_timeout held stable until rsp_valid && rsp_ready at an edge, then -> IDLE with rsp_valid=0.
- rsp_pkt always echoes udp_check, opcode, byte_mask, dwaddr of the request.
- Latency:
  - Pop at edge 0; rd/wr_en high from edge 0 to the edge after done.
  - rsp_valid rises one edge after the done edge.
  - Next pop is no earlier than the edge after response acceptance.
- One request outstanding at a time. No pop while in CFG or RESP, so back-pressure propagates into the FIFO.
- cfg_mgmt_rd_wr_done seen outside CFG: ignored.
- rsp_ready may be high before rsp_valid; no effect in IDLE/CFG.

Test Plan:
- Read: entry {dv=1, udp_check=16'hBEEF, op=RD, mask=4'hF, dwaddr=10'h000}; model returns 32'h7022_10EE after 3 cycles -> rd_en high exactly 4 cycles; rsp_pkt={16'hBEEF, 2'b00, 4'hF, 10'h000, 32'h7022_10EE}; rsp_timeout=0.
- Write: op=WR, mask=4'h3, dwaddr=10'h001, data=32'h0000_0006 -> wr_en, byte_en=4'h3, di=32'h6, wr_readonly=0; response echoes data 32'h6 after done.
- Timeout: TIMEOUT=16, model never asserts done on a read -> rd_en high 16 cycles then low; rsp_timeout=1; data=32'hFFFF_FFFF; next entry processed normally.
- Drops and masks: entries with dv=0, op=2'b11, and WR mask=0 -> drop_cnt=2; one immediate response for the mask=0 write; zero cfg strobes.
- Back-pressure: 3 queued reads, rsp_ready low for 20 cycles -> first response held stable; fifo_rd_en stays 0; all 3 responses delivered in order once ready=1.
- Reset mid-CFG: assert rst while rd_en=1 -> rd_en and rsp_valid 0 immediately; after release, the next FIFO entry is executed cleanly.

Source files
------------

// File: rtl/pciecfg_exec.sv
// rtl/pciecfg_exec.sv - executes queued NetTLP config requests on the PCIe cfg_mgmt port
module pciecfg_exec #(
  parameter int   TIMEOUT     = 255,
  parameter logic WR_READONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [64:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [9:0]  cfg_mgmt_dwaddr,
  output logic [3:0]  cfg_mgmt_byte_en,
  output logic [31:0] cfg_mgmt_di,
  output logic        cfg_mgmt_rd_en,
  output logic        cfg_mgmt_wr_en,
  output logic        cfg_mgmt_wr_readonly,
  input  logic [31:0] cfg_mgmt_do,
  input  logic        cfg_mgmt_rd_wr_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_pkt,
  output logic        rsp_timeout,
  output logic [15:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, CFG, RESP} state_t;

  localparam logic [1:0]  OP_RD    = 2'b00;
  localparam logic [1:0]  OP_WR    = 2'b01;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [31:0] hdr_q;
  logic        rd_en_q, wr_en_q, wr_ro_q;
  logic [9:0]  dwaddr_q;
  logic [3:0]  byte_en_q;
  logic [31:0] di_q;
  logic        rsp_valid_q, rsp_to_q;
  logic [63:0] rsp_pkt_q;
  logic [15:0] drop_q;

  logic        pop;
  logic        drop_entry;
  logic        imm_entry;
  logic [1:0]  in_op;

  assign in_op      = fifo_dout[47:46];
  assign pop        = !rst && (state_q == IDLE) && !fifo_empty;
  assign drop_entry = !fifo_dout[64] || in_op[1];
  // A write with no byte enabled has nothing to do on the core; answer it straight away.
  assign imm_entry  = (in_op == OP_WR) && (fifo_dout[45:42] == 4'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_ro_q     <= 1'b0;
      dwaddr_q    <= '0;
      byte_en_q   <= '0;
      di_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_pkt_q   <= '0;
      drop_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (drop_entry) begin
              drop_q <= drop_q + 16'd1;
            end else if (imm_entry) begin
              rsp_pkt_q   <= fifo_dout[63:0];
              rsp_to_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              hdr_q     <= fifo_dout[63:32];
              dwaddr_q  <= fifo_dout[41:32];
              byte_en_q <= fifo_dout[45:42];
              di_q      <= fifo_dout[31:0];
              rd_en_q   <= (in_op == OP_RD);
              wr_en_q   <= (in_op == OP_WR);
              wr_ro_q   <= (in_op == OP_WR) && WR_READONLY;
              cnt_q     <= '0;
              state_q   <= CFG;
            end
          end
        end
        CFG: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (cfg_mgmt_rd_wr_done || (cnt_q == TMO_LAST)) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_ro_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_to_q    <= !cfg_mgmt_rd_wr_done;
            if (rd_en_q)
              rsp_pkt_q <= {hdr_q, cfg_mgmt_rd_wr_done ? cfg_mgmt_do : 32'hFFFF_FFFF};
            else
              rsp_pkt_q <= {hdr_q, di_q};
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en           = pop;
  assign cfg_mgmt_dwaddr      = dwaddr_q;
  assign cfg_mgmt_byte_en     = byte_en_q;
  assign cfg_mgmt_di          = di_q;
  assign cfg_mgmt_rd_en       = rd_en_q;
  assign cfg_mgmt_wr_en       = wr_en_q;
  assign cfg_mgmt_wr_readonly = wr_ro_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_pkt              = rsp_pkt_q;
  assign rsp_timeout          = rsp_to_q;
  assign drop_cnt             = drop_q;
endmodule
